// File: rtl/matrix_capture.sv
// matrix_capture: rebuilds the 16x16 dot-matrix frame from the driver's serial row/column chains
// and flags row-select and column-length protocol errors.
module matrix_capture #(
  parameter bit SWAP_PAIRS = 1'b1,
  parameter int NBITS      = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rclk,
  input  logic        rsdi,
  input  logic        cclk,
  input  logic        csdi,
  input  logic        le,
  input  logic [3:0]  rd_row,
  output logic [15:0] rd_data,
  output logic        row_strobe,
  output logic [3:0]  row_idx,
  output logic [15:0] row_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt,
  output logic        err_row,
  output logic        err_len
);
  localparam logic [4:0] NB = 5'(NBITS);
  logic        rclk_q, cclk_q, le_q;
  logic        r_rise, c_rise, le_rise;
  logic [15:0] rowsr_q, rowsr_d, colsr_q, colsr_d;
  logic [4:0]  bitcnt_q, bitcnt_d;
  logic [15:0] fb_q [16];
  logic        strobe_q, strobe_d, fdone_q, fdone_d, erow_q, erow_d, elen_q, elen_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] data_q, data_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [3:0]  p, lrow;
  logic [4:0]  nzero;
  logic        sel_ok, commit;
  assign r_rise  = rclk & ~rclk_q;
  assign c_rise  = cclk & ~cclk_q;
  assign le_rise = le & ~le_q;
  // row select is active-low: exactly one zero marks the driven physical row
  always_comb begin
    p     = '0;
    nzero = '0;
    for (int i = 0; i < 16; i++)
      if (!rowsr_q[i]) begin
        p     = 4'(i);
        nzero = nzero + 5'd1;
      end
  end
  assign sel_ok = (nzero == 5'd1);
  assign commit = le_rise & sel_ok;
  assign lrow   = SWAP_PAIRS ? (p ^ 4'd1) : p;
  always_comb begin
    rowsr_d  = r_rise ? {rowsr_q[14:0], rsdi} : rowsr_q;
    colsr_d  = c_rise ? {colsr_q[14:0], csdi} : colsr_q;
    bitcnt_d = le_rise ? {4'd0, c_rise}
             : (c_rise && bitcnt_q != 5'd31) ? bitcnt_q + 5'd1 : bitcnt_q;
    strobe_d = commit;
    idx_d    = commit ? lrow : idx_q;
    data_d   = commit ? colsr_q : data_q;
    fdone_d  = commit && (p == 4'd15);
    fcnt_d   = fcnt_q + 8'(fdone_d);
    erow_d   = erow_q | (le_rise & ~sel_ok);
    elen_d   = elen_q | (le_rise & (bitcnt_q != NB));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rclk_q   <= 1'b0;
      cclk_q   <= 1'b0;
      le_q     <= 1'b0;
      rowsr_q  <= 16'hFFFF;
      colsr_q  <= '0;
      bitcnt_q <= '0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      data_q   <= '0;
      fdone_q  <= 1'b0;
      fcnt_q   <= '0;
      erow_q   <= 1'b0;
      elen_q   <= 1'b0;
    end else begin
      rclk_q   <= rclk;
      cclk_q   <= cclk;
      le_q     <= le;
      rowsr_q  <= rowsr_d;
      colsr_q  <= colsr_d;
      bitcnt_q <= bitcnt_d;
      strobe_q <= strobe_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      fdone_q  <= fdone_d;
      fcnt_q   <= fcnt_d;
      erow_q   <= erow_d;
      elen_q   <= elen_d;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) fb_q[i] <= '0;
    end else if (commit) begin
      fb_q[lrow] <= colsr_q;
    end
  assign rd_data    = fb_q[rd_row];
  assign row_strobe = strobe_q;
  assign row_idx    = idx_q;
  assign row_data   = data_q;
  assign frame_done = fdone_q;
  assign frame_cnt  = fcnt_q;
  assign err_row    = erow_q;
  assign err_len    = elen_q;
endmodule
